traffic_light_ctrl: RTL

Intersection phase controller for a highway / side-road crossing. It consumes the registered `y_out` of the side-road vehicle sequence detector as `car_detect`. It grants the side road a green phase only after the highway has held green for a guaranteed minimum time. It drives the two light heads directly through Moore-decoded outputs.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/phase_timer.sv | 40 ++++
 rtl/traffic_light_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// ============================================================================
// traffic_pkg : light-head encodings and FSM phase type for traffic_light_ctrl
// Revision    : 1.0
// ============================================================================
`default_nettype none

package traffic_pkg;

  typedef logic [1:0] light_t;

  localparam light_t RED    = 2'b00;
  localparam light_t YELLOW = 2'b01;
  localparam light_t GREEN  = 2'b10;

  typedef enum logic [2:0] {
    HWY_G  = 3'd0,
    HWY_Y  = 3'd1,
    RED_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_B  = 3'd5
  } phase_t;

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// ============================================================================
// phase_timer : saturating cycle counter, cleared on each phase change
// Revision    : 1.0
// ============================================================================
`default_nettype none

module phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  output logic [TIMER_W-1:0] count
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != {TIMER_W{1'b1}}) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
// ============================================================================
// traffic_light_ctrl : highway/side-road phase FSM with latched side request
// Revision           : 1.0
// ============================================================================
`default_nettype none

module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int HWY_MIN_GREEN = 8,
  parameter int YELLOW_TIME   = 3,
  parameter int ALL_RED_TIME  = 1,
  parameter int SIDE_GREEN    = 5,
  parameter int TIMER_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       car_detect,
  output logic [1:0] hwy_light,
  output logic [1:0] side_light,
  output logic       side_req
);

  // Terminal counts: a phase of N cycles ends when the timer reaches N-1.
  localparam logic [TIMER_W-1:0] C_HWY_LAST = TIMER_W'(HWY_MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] C_YEL_LAST = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] C_RED_LAST = TIMER_W'(ALL_RED_TIME - 1);
  localparam logic [TIMER_W-1:0] C_SID_LAST = TIMER_W'(SIDE_GREEN - 1);

  phase_t             state_q;
  phase_t             state_d;
  logic               req_q;
  logic               req_d;
  logic [TIMER_W-1:0] timer;
  logic               timer_clear;

  phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clear),
    .count (timer)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HWY_G:   if ((timer >= C_HWY_LAST) && req_q) state_d = HWY_Y;
      HWY_Y:   if (timer >= C_YEL_LAST)            state_d = RED_A;
      RED_A:   if (timer >= C_RED_LAST)            state_d = SIDE_G;
      SIDE_G:  if (timer >= C_SID_LAST)            state_d = SIDE_Y;
      SIDE_Y:  if (timer >= C_YEL_LAST)            state_d = RED_B;
      RED_B:   if (timer >= C_RED_LAST)            state_d = HWY_G;
      default:                                     state_d = HWY_G;
    endcase
  end

  assign timer_clear = (state_d != state_q);

  // Ignoring the detector while the side road is served keeps a parked car
  // from re-requesting and starving the highway.
  always_comb begin
    req_d = req_q;
    if (car_detect && (state_q != SIDE_G) && (state_q != SIDE_Y)) begin
      req_d = 1'b1;
    end
    if ((state_d == SIDE_G) && (state_q != SIDE_G)) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= HWY_G;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    hwy_light  = RED;
    side_light = RED;
    unique case (state_q)
      HWY_G:   hwy_light  = GREEN;
      HWY_Y:   hwy_light  = YELLOW;
      SIDE_G:  side_light = GREEN;
      SIDE_Y:  side_light = YELLOW;
      default: begin
        hwy_light  = RED;
        side_light = RED;
      end
    endcase
  end

  assign side_req = req_q;

endmodule

`default_nettype wire
